// File: rtl/reg_map_table_if.sv
// reg_map_table_if: dispatch, ROB-revert and checkpoint ports of the register map table
interface reg_map_table_if #(
  parameter int NUM_ARCH_REGS      = 32,
  parameter int NUM_PHYS_REGS      = 64,
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int ROB_DEPTH          = 16
);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int LOG_COLS = $clog2(CHECKPOINT_COLUMNS);
  localparam int LOG_ROB  = $clog2(ROB_DEPTH);
  logic                DUT_error;
  logic [LOG_ARCH-1:0] source_arch_reg_tag_A, source_arch_reg_tag_B;
  logic [LOG_PHYS-1:0] source_phys_reg_tag_A, source_phys_reg_tag_B;
  logic                rename_valid;
  logic [LOG_ARCH-1:0] rename_dest_arch_reg_tag;
  logic [LOG_PHYS-1:0] rename_new_phys_reg_tag, rename_old_phys_reg_tag;
  logic                revert_valid;
  logic [LOG_ARCH-1:0] revert_dest_arch_reg_tag;
  logic [LOG_PHYS-1:0] revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag;
  logic                save_checkpoint_valid;
  logic [LOG_ROB-1:0]  save_checkpoint_ROB_index;
  logic [LOG_COLS-1:0] save_checkpoint_safe_column;
  logic                checkpoint_full;
  logic                restore_checkpoint_valid, restore_checkpoint_speculate_failed;
  logic [LOG_ROB-1:0]  restore_checkpoint_ROB_index;
  logic [LOG_COLS-1:0] restore_checkpoint_safe_column;
  logic                restore_checkpoint_success;
  modport master (
    input  DUT_error, source_phys_reg_tag_A, source_phys_reg_tag_B, rename_old_phys_reg_tag,
           save_checkpoint_safe_column, checkpoint_full, restore_checkpoint_success,
    output source_arch_reg_tag_A, source_arch_reg_tag_B, rename_valid, rename_dest_arch_reg_tag,
           rename_new_phys_reg_tag, revert_valid, revert_dest_arch_reg_tag,
           revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag,
           save_checkpoint_valid, save_checkpoint_ROB_index, restore_checkpoint_valid,
           restore_checkpoint_speculate_failed, restore_checkpoint_ROB_index,
           restore_checkpoint_safe_column
  );
  modport slave (
    output DUT_error, source_phys_reg_tag_A, source_phys_reg_tag_B, rename_old_phys_reg_tag,
           save_checkpoint_safe_column, checkpoint_full, restore_checkpoint_success,
    input  source_arch_reg_tag_A, source_arch_reg_tag_B, rename_valid, rename_dest_arch_reg_tag,
           rename_new_phys_reg_tag, revert_valid, revert_dest_arch_reg_tag,
           revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag,
           save_checkpoint_valid, save_checkpoint_ROB_index, restore_checkpoint_valid,
           restore_checkpoint_speculate_failed, restore_checkpoint_ROB_index,
           restore_checkpoint_safe_column
  );
endinterface

// File: rtl/reg_map_table.sv
// reg_map_table: architectural-to-physical register map with checkpoint save/restore columns
module reg_map_table #(
  parameter int NUM_ARCH_REGS      = 32,
  parameter int NUM_PHYS_REGS      = 64,
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int ROB_DEPTH          = 16
) (
  input logic CLK,
  input logic RST,
  reg_map_table_if.slave bus
);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int LOG_COLS = $clog2(CHECKPOINT_COLUMNS);
  localparam int LOG_ROB  = $clog2(ROB_DEPTH);
  typedef logic [LOG_PHYS-1:0] map_t [NUM_ARCH_REGS];
  map_t                        map_q, map_d;
  map_t                        col_map_q [CHECKPOINT_COLUMNS];
  map_t                        col_map_d [CHECKPOINT_COLUMNS];
  logic [CHECKPOINT_COLUMNS-1:0] col_valid_q, col_valid_d;
  logic [LOG_ROB-1:0]          col_rob_q [CHECKPOINT_COLUMNS];
  logic [LOG_ROB-1:0]          col_rob_d [CHECKPOINT_COLUMNS];
  logic [LOG_COLS-1:0]         tail_q, tail_d;
  logic                        err_q, err_d;
  logic                        vtm, fr_req, hi;
  logic [LOG_COLS-1:0]         rcol;
  assign rcol   = bus.restore_checkpoint_safe_column;
  assign vtm    = col_valid_q[rcol] && (col_rob_q[rcol] == bus.restore_checkpoint_ROB_index);
  assign fr_req = bus.restore_checkpoint_valid & bus.restore_checkpoint_speculate_failed;
  assign hi     = bus.revert_valid | fr_req;
  assign bus.source_phys_reg_tag_A       = map_q[bus.source_arch_reg_tag_A];
  assign bus.source_phys_reg_tag_B       = map_q[bus.source_arch_reg_tag_B];
  assign bus.rename_old_phys_reg_tag     = map_q[bus.rename_dest_arch_reg_tag];
  assign bus.save_checkpoint_safe_column = tail_q;
  assign bus.checkpoint_full             = col_valid_q[tail_q];
  assign bus.DUT_error                   = err_q;
  // a failed restore pre-empted by a revert does not happen, so it reports no success
  assign bus.restore_checkpoint_success  = bus.restore_checkpoint_valid & vtm & ~(fr_req & bus.revert_valid);
  always_comb begin
    map_d       = map_q;
    col_map_d   = col_map_q;
    col_valid_d = col_valid_q;
    col_rob_d   = col_rob_q;
    tail_d      = tail_q;
    err_d       = (bus.save_checkpoint_valid & hi) | (bus.rename_valid & (hi | bus.save_checkpoint_valid));
    if (bus.restore_checkpoint_valid & ~bus.restore_checkpoint_speculate_failed & vtm)
      col_valid_d[rcol] = 1'b0;
    if (bus.revert_valid) begin
      if (bus.revert_dest_arch_reg_tag != '0) begin
        map_d[bus.revert_dest_arch_reg_tag] = bus.revert_safe_dest_phys_reg_tag;
        err_d = err_d | (map_q[bus.revert_dest_arch_reg_tag] != bus.revert_speculated_dest_phys_reg_tag);
      end
    end else if (fr_req) begin
      if (vtm) begin
        map_d             = col_map_q[rcol];
        tail_d            = rcol;
        col_valid_d       = '0;
        col_valid_d[rcol] = 1'b1;
      end
    end else if (bus.save_checkpoint_valid) begin
      col_valid_d[tail_q] = 1'b1;
      col_rob_d[tail_q]   = bus.save_checkpoint_ROB_index;
      col_map_d[tail_q]   = map_q;
      tail_d              = tail_q + 1'b1;
      err_d               = err_d | col_valid_q[tail_q];
    end else if (bus.rename_valid && bus.rename_dest_arch_reg_tag != '0) begin
      map_d[bus.rename_dest_arch_reg_tag] = bus.rename_new_phys_reg_tag;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) map_q[i] <= LOG_PHYS'(i);
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        col_rob_q[c] <= '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) col_map_q[c][i] <= '0;
      end
      col_valid_q <= '0;
      tail_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      map_q       <= map_d;
      col_map_q   <= col_map_d;
      col_valid_q <= col_valid_d;
      col_rob_q   <= col_rob_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_reg_map_table.sv
// tb_reg_map_table: vector-table bench for reg_map_table with a queue scoreboard for DUT_error
module tb_reg_map_table;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  reg_map_table_if bus ();
  reg_map_table dut (.CLK(CLK), .RST(RST), .bus(bus));
  // op bits: 1 rename, 2 revert, 4 save, 8 restore, 16 speculate_failed
  typedef struct {
    int op, rd, rn, vd, vs, vp, rob, col, sa, sb;
    int ea, eb, eo, es, ef, et, ee;
  } vec_t;
  vec_t tbl [31];
  int   err_q [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total_cnt++;
    if (act !== 32'(exp)) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else pass_cnt++;
  endtask
  task automatic apply(input vec_t v);
    bus.rename_valid                        = (v.op & 1) != 0;
    bus.revert_valid                        = (v.op & 2) != 0;
    bus.save_checkpoint_valid               = (v.op & 4) != 0;
    bus.restore_checkpoint_valid            = (v.op & 8) != 0;
    bus.restore_checkpoint_speculate_failed = (v.op & 16) != 0;
    bus.rename_dest_arch_reg_tag            = 5'(v.rd);
    bus.rename_new_phys_reg_tag             = 6'(v.rn);
    bus.revert_dest_arch_reg_tag            = 5'(v.vd);
    bus.revert_safe_dest_phys_reg_tag       = 6'(v.vs);
    bus.revert_speculated_dest_phys_reg_tag = 6'(v.vp);
    bus.save_checkpoint_ROB_index           = 4'(v.rob);
    bus.restore_checkpoint_ROB_index        = 4'(v.rob);
    bus.restore_checkpoint_safe_column      = 2'(v.col);
    bus.source_arch_reg_tag_A               = 5'(v.sa);
    bus.source_arch_reg_tag_B               = 5'(v.sb);
  endtask
  task automatic step(input int idx);
    vec_t v;
    int   e;
    v = tbl[idx];
    apply(v);
    err_q.push_back(v.ee);
    #1;
    chk($sformatf("row%0d srcA", idx), 32'(bus.source_phys_reg_tag_A), v.ea);
    chk($sformatf("row%0d srcB", idx), 32'(bus.source_phys_reg_tag_B), v.eb);
    chk($sformatf("row%0d old", idx), 32'(bus.rename_old_phys_reg_tag), v.eo);
    chk($sformatf("row%0d success", idx), 32'(bus.restore_checkpoint_success), v.es);
    chk($sformatf("row%0d full", idx), 32'(bus.checkpoint_full), v.ef);
    chk($sformatf("row%0d tail", idx), 32'(bus.save_checkpoint_safe_column), v.et);
    @(posedge CLK);
    #1;
    e = err_q.pop_front();
    chk($sformatf("row%0d DUT_error", idx), 32'(bus.DUT_error), e);
  endtask
  initial begin
    //           op  rd  rn vd vs vp rob col sa  sb  ea  eb eo  es ef et ee
    tbl[0]  = '{ 0,  0,  0, 0, 0, 0, 0, 0,  5, 31,  5, 31, 0, 0, 0, 0, 0};
    tbl[1]  = '{ 1,  3, 40, 0, 0, 0, 0, 0,  3,  0,  3,  0, 3, 0, 0, 0, 0};
    tbl[2]  = '{ 0,  3,  0, 0, 0, 0, 0, 0,  3,  0, 40,  0,40, 0, 0, 0, 0};
    tbl[3]  = '{ 2,  3,  0, 3, 3,40, 0, 0,  3,  0, 40,  0,40, 0, 0, 0, 0};
    tbl[4]  = '{ 2,  3,  0, 3, 3,41, 0, 0,  3,  0,  3,  0, 3, 0, 0, 0, 1};
    tbl[5]  = '{ 0,  3,  0, 0, 0, 0, 0, 0,  3,  0,  3,  0, 3, 0, 0, 0, 0};
    tbl[6]  = '{ 4,  4,  0, 0, 0, 0, 7, 0,  4,  0,  4,  0, 4, 0, 0, 0, 0};
    tbl[7]  = '{ 1,  4, 50, 0, 0, 0, 0, 0,  4,  0,  4,  0, 4, 0, 0, 1, 0};
    tbl[8]  = '{24,  4,  0, 0, 0, 0, 7, 0,  4,  0, 50,  0,50, 1, 0, 1, 0};
    tbl[9]  = '{ 0,  4,  0, 0, 0, 0, 0, 0,  4,  0,  4,  0, 4, 0, 1, 0, 0};
    tbl[10] = '{ 8,  0,  0, 0, 0, 0, 2, 1,  0,  0,  0,  0, 0, 0, 1, 0, 0};
    tbl[11] = '{ 8,  0,  0, 0, 0, 0, 7, 0,  0,  0,  0,  0, 0, 1, 1, 0, 0};
    tbl[12] = '{ 0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0};
    tbl[13] = '{ 4,  0,  0, 0, 0, 0, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0};
    tbl[14] = '{ 4,  0,  0, 0, 0, 0, 2, 0,  0,  0,  0,  0, 0, 0, 0, 1, 0};
    tbl[15] = '{ 4,  0,  0, 0, 0, 0, 3, 0,  0,  0,  0,  0, 0, 0, 0, 2, 0};
    tbl[16] = '{ 4,  0,  0, 0, 0, 0, 4, 0,  0,  0,  0,  0, 0, 0, 0, 3, 0};
    tbl[17] = '{ 0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 1, 0, 0};
    tbl[18] = '{ 4,  0,  0, 0, 0, 0, 5, 0,  0,  0,  0,  0, 0, 0, 1, 0, 1};
    tbl[19] = '{ 0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 1, 1, 0};
    tbl[20] = '{24,  0,  0, 0, 0, 0, 5, 0,  0,  0,  0,  0, 0, 1, 1, 1, 0};
    tbl[21] = '{ 8,  0,  0, 0, 0, 0, 5, 0,  0,  0,  0,  0, 0, 1, 1, 0, 0};
    tbl[22] = '{ 5,  6, 45, 0, 0, 0, 6, 0,  6,  0,  6,  0, 6, 0, 0, 0, 1};
    tbl[23] = '{ 0,  6,  0, 0, 0, 0, 0, 0,  6,  0,  6,  0, 6, 0, 0, 1, 0};
    tbl[24] = '{ 1,  0, 33, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 1, 0};
    tbl[25] = '{ 0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 1, 0};
    tbl[26] = '{ 1,  7, 20, 0, 0, 0, 0, 0,  7,  0,  7,  0, 7, 0, 0, 1, 0};
    tbl[27] = '{24,  7,  0, 0, 0, 0, 9, 0,  7,  0, 20,  0,20, 0, 0, 1, 0};
    tbl[28] = '{ 0,  7,  0, 0, 0, 0, 0, 0,  7,  0, 20,  0,20, 0, 0, 1, 0};
    tbl[29] = '{ 3,  8, 21, 7, 7,20, 0, 0,  7,  8, 20,  8, 8, 0, 0, 1, 1};
    tbl[30] = '{ 0,  8,  0, 0, 0, 0, 0, 0,  7,  8,  7,  8, 8, 0, 0, 1, 0};
    apply(tbl[12]);
    #12;
    RST = 1'b0;
    for (int i = 0; i < 31; i++) step(i);
    // rename 9 -> 60, then assert reset asynchronously in the middle of a failed restore
    apply('{1, 9, 60, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0});
    @(posedge CLK);
    #1;
    apply('{24, 0, 0, 0, 0, 0, 6, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("pre-reset success", 32'(bus.restore_checkpoint_success), 1);
    chk("pre-reset srcA", 32'(bus.source_phys_reg_tag_A), 60);
    #2;
    RST = 1'b1;
    #1;
    chk("reset success", 32'(bus.restore_checkpoint_success), 0);
    chk("reset srcA", 32'(bus.source_phys_reg_tag_A), 9);
    chk("reset full", 32'(bus.checkpoint_full), 0);
    chk("reset tail", 32'(bus.save_checkpoint_safe_column), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    // a pending DUT_error is cleared the instant reset is asserted
    apply('{2, 0, 0, 5, 5, 33, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0});
    @(posedge CLK);
    #1;
    chk("revert mismatch error", 32'(bus.DUT_error), 1);
    apply(tbl[12]);
    #2;
    RST = 1'b1;
    #1;
    chk("reset clears error", 32'(bus.DUT_error), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
